exmem_stage: RTL
================

EXMEM_STAGE -- requirements
Module: exmem_stage

Interface
REQ-001 SHALL have parameter HALT_HOLD, default 1, meaning that when 1, mem_halt stays asserted after a retired halt until reset.
REQ-002 SHALL use one clock; reset is asynchronous and active-low: CLK  in  1  rising-edge clock; nRST  in  1  asynchronous active-low reset.
REQ-003 SHALL have inputs ex_valid 1, ex_instr 32, ex_rd 5, ex_regwrite 1, ex_memread 1, ex_memwrite 1, ex_halt 1, ex_aluout 32 and ex_storedata 32, carrying the EX-stage result.
REQ-004 SHALL have input flush 1, which replaces the next captured entry with a bubble.
REQ-005 SHALL have input dhit 1 (data memory access complete) and input dmemload 32 (load data).
REQ-006 SHALL have outputs dmemREN 1, dmemWEN 1, dmemaddr 32 and dmemstore 32, driven to data memory.
REQ-007 SHALL have output stall_out 1, which freezes the upstream IF/ID/EX stages.
REQ-008 SHALL have outputs exmem_rd 5, exmem_regwrite 1, exmem_instr 32, exmem_fwd_data 32 and exmem_is_load 1, which feed the forward unit (rdm, exmemRW, exmem_instr) and the hazard logic.
REQ-009 SHALL have outputs mem_valid 1, mem_rd 5, mem_regwrite 1, mem_wdata 32, mem_instr 32 and mem_halt 1, which form the MEM/WB register.

Function
REQ-010 SHALL implement states EMPTY, HOLD, MEMWAIT and HALTED.
REQ-011 SHALL treat edge "advance" as: state is EMPTY or HOLD, or state is MEMWAIT with dhit=1.
REQ-012 SHALL capture the ex_* inputs into the entry register on an advance edge when ex_valid=1 and flush=0, and SHALL capture a bubble (valid=0) otherwise.
REQ-013 SHALL transition on an advance edge to MEMWAIT if the captured entry is valid with memread or memwrite, else to HOLD if it is valid, else to EMPTY.
REQ-014 SHALL assert dmemREN = MEMWAIT & memread and dmemWEN = MEMWAIT & memwrite combinationally from the entry, with dmemaddr = aluout and dmemstore = storedata.
REQ-015 SHALL drive stall_out = MEMWAIT & !dhit, so that the upstream stages are released in the dhit cycle itself.
REQ-016 SHALL ignore flush while stall_out=1; the older memory op completes, and flush is sampled again at the advance edge.
REQ-017 SHALL ignore dhit outside MEMWAIT.
REQ-018 SHALL update the MEM/WB outputs on every advance edge from the entry being retired: mem_valid = entry valid, mem_wdata = dmemload for loads, else aluout.
REQ-019 SHALL drive mem_valid=0 on every edge where state is MEMWAIT and dhit=0.
REQ-020 SHALL give a non-memory instruction a latency of exactly 1 cycle from the capture edge to mem_valid=1.
REQ-021 SHALL give a memory op a latency of 1 + (number of dhit=0 cycles in MEMWAIT) cycles.
REQ-022 SHALL drive exmem_regwrite = valid & regwrite & (rd != 0) and exmem_rd = rd, and SHALL drive both to 0 when the entry is invalid.
REQ-023 SHALL drive exmem_fwd_data = aluout and exmem_is_load = valid & memread.
REQ-024 SHALL, when a valid halt entry retires, assert mem_halt=1 and enter HALTED.
REQ-025 SHALL in HALTED ignore all inputs, hold dmemREN/dmemWEN=0 and stall_out=1, and hold mem_valid=0.
REQ-026 SHALL, when HALT_HOLD=0, pulse mem_halt for only 1 cycle.
REQ-027 SHALL give flush priority over ex_valid when both are asserted at an advance edge.
REQ-028 SHALL never assert dmemREN and dmemWEN together; an entry with both memread and memwrite is treated as a load only.

Reset
REQ-029 SHALL, on nRST=0, immediately clear state to EMPTY and clear all entry fields and all outputs to 0, including dmemREN, dmemWEN and stall_out, independent of CLK.
REQ-030 SHALL, on reset asserted mid-MEMWAIT, drop the memory request combinationally and lose the in-flight op without a retire.
REQ-031 SHALL resume normal capture at the first rising CLK edge after nRST deasserts.

Verification
REQ-032 SHALL cover ALU op: add rd=5, aluout=0x10 accepted at edge 0 -> exmem_regwrite=1 and exmem_rd=5 in cycle 0-1; mem_valid=1, mem_wdata=0x10 after edge 1; stall_out never 1.
REQ-033 SHALL cover load with 3-cycle wait: lw rd=8, aluout=0x100, dhit=1 on 3rd cycle, dmemload=0xDEADBEEF -> dmemREN=1 and dmemaddr=0x100 for 3 cycles, stall_out=1 for 2, mem_wdata=0xDEADBEEF, exmem_is_load=1 throughout.
REQ-034 SHALL cover store followed by flush: sw with storedata=0xA5A5A5A5, flush=1 during MEMWAIT -> store completes with dmemWEN=1 until dhit, and the next entry captured is a bubble only if flush=1 at the advance edge.
REQ-035 SHALL cover write to $zero: add rd=0, regwrite=1 -> exmem_regwrite=0, mem_regwrite passes 1 unchanged.
REQ-036 SHALL cover halt: halt entry retires -> mem_halt=1 held, stall_out=1, and later ex_valid pulses produce no mem_valid.
REQ-037 SHALL cover async reset mid-load: nRST=0 between edges during MEMWAIT -> dmemREN=0 in the same cycle, state EMPTY, and no mem_valid after release.

Source files
------------

// File: rtl/exmem_stage.sv
// rtl/exmem_stage.sv - EX/MEM pipeline stage with data-memory handshake and MEM/WB register
//
// Purpose: holds one instruction coming out of EX, issues its data-memory
// access (if any), stalls the upstream stages while the access is pending,
// and retires the entry into the MEM/WB register.
//
// Ports:
//   CLK, nRST                 clock (rising edge), asynchronous active-low reset
//   ex_*                      EX-stage result offered for capture
//   flush                     turns the next captured entry into a bubble
//   dhit, dmemload            data-memory completion and load data
//   dmemREN/WEN/addr/store    data-memory request
//   stall_out                 freezes IF/ID/EX
//   exmem_*                   forward-unit / hazard-logic view of the entry
//   mem_*                     MEM/WB register
//
// Parameter HALT_HOLD: 1 keeps mem_halt asserted until reset, 0 pulses it.

module exmem_stage #(
  parameter bit HALT_HOLD = 1'b1
) (
  input  logic        CLK,
  input  logic        nRST,
  input  logic        ex_valid,
  input  logic [31:0] ex_instr,
  input  logic [4:0]  ex_rd,
  input  logic        ex_regwrite,
  input  logic        ex_memread,
  input  logic        ex_memwrite,
  input  logic        ex_halt,
  input  logic [31:0] ex_aluout,
  input  logic [31:0] ex_storedata,
  input  logic        flush,
  input  logic        dhit,
  input  logic [31:0] dmemload,
  output logic        dmemREN,
  output logic        dmemWEN,
  output logic [31:0] dmemaddr,
  output logic [31:0] dmemstore,
  output logic        stall_out,
  output logic [4:0]  exmem_rd,
  output logic        exmem_regwrite,
  output logic [31:0] exmem_instr,
  output logic [31:0] exmem_fwd_data,
  output logic        exmem_is_load,
  output logic        mem_valid,
  output logic [4:0]  mem_rd,
  output logic        mem_regwrite,
  output logic [31:0] mem_wdata,
  output logic [31:0] mem_instr,
  output logic        mem_halt
);

  typedef enum logic [1:0] {
    EMPTY   = 2'd0,
    HOLD    = 2'd1,
    MEMWAIT = 2'd2,
    HALTED  = 2'd3
  } state_t;

  state_t state, state_n;

  // entry register
  logic        e_valid;
  logic [31:0] e_instr;
  logic [4:0]  e_rd;
  logic        e_regwrite;
  logic        e_memread;
  logic        e_memwrite;
  logic        e_halt;
  logic [31:0] e_aluout;
  logic [31:0] e_storedata;

  logic advance;
  logic cap_valid;
  logic retire_halt;

  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      state <= EMPTY;
    end else begin
      state <= state_n;
    end
  end

  always_comb begin
    advance     = 1'b0;
    state_n     = state;
    cap_valid   = ex_valid & ~flush;   // flush wins over ex_valid
    retire_halt = 1'b0;
    dmemREN     = 1'b0;
    dmemWEN     = 1'b0;
    stall_out   = 1'b0;

    case (state)
      EMPTY, HOLD: advance = 1'b1;
      MEMWAIT: begin
        advance = dhit;
        dmemREN = e_memread;
        // an entry flagged both read and write is treated as a load
        dmemWEN = e_memwrite & ~e_memread;
        // upstream is released in the dhit cycle itself
        stall_out = ~dhit;
      end
      HALTED: stall_out = 1'b1;
      default: ;
    endcase

    retire_halt = advance & e_valid & e_halt;

    if (advance) begin
      if (retire_halt) begin
        state_n = HALTED;
      end else if (cap_valid & (ex_memread | ex_memwrite)) begin
        state_n = MEMWAIT;
      end else if (cap_valid) begin
        state_n = HOLD;
      end else begin
        state_n = EMPTY;
      end
    end
  end

  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      e_valid      <= 1'b0;
      e_instr      <= '0;
      e_rd         <= '0;
      e_regwrite   <= 1'b0;
      e_memread    <= 1'b0;
      e_memwrite   <= 1'b0;
      e_halt       <= 1'b0;
      e_aluout     <= '0;
      e_storedata  <= '0;
      mem_valid    <= 1'b0;
      mem_rd       <= '0;
      mem_regwrite <= 1'b0;
      mem_wdata    <= '0;
      mem_instr    <= '0;
      mem_halt     <= 1'b0;
    end else if (advance) begin
      // retire the current entry into MEM/WB
      mem_valid    <= e_valid;
      mem_rd       <= e_rd;
      mem_regwrite <= e_regwrite;
      mem_instr    <= e_instr;
      mem_wdata    <= e_memread ? dmemload : e_aluout;
      if (retire_halt) begin
        mem_halt <= 1'b1;
      end else if (!HALT_HOLD) begin
        mem_halt <= 1'b0;
      end

      // capture the next entry; a halting stage captures nothing further
      if (cap_valid && !retire_halt) begin
        e_valid     <= 1'b1;
        e_instr     <= ex_instr;
        e_rd        <= ex_rd;
        e_regwrite  <= ex_regwrite;
        e_memread   <= ex_memread;
        e_memwrite  <= ex_memwrite;
        e_halt      <= ex_halt;
        e_aluout    <= ex_aluout;
        e_storedata <= ex_storedata;
      end else begin
        e_valid     <= 1'b0;
        e_instr     <= '0;
        e_rd        <= '0;
        e_regwrite  <= 1'b0;
        e_memread   <= 1'b0;
        e_memwrite  <= 1'b0;
        e_halt      <= 1'b0;
        e_aluout    <= '0;
        e_storedata <= '0;
      end
    end else begin
      // waiting on memory or halted: nothing retires this edge
      mem_valid <= 1'b0;
      if (!HALT_HOLD) begin
        mem_halt <= 1'b0;
      end
    end
  end

  assign dmemaddr       = e_aluout;
  assign dmemstore      = e_storedata;
  assign exmem_rd       = e_valid ? e_rd : 5'd0;
  assign exmem_regwrite = e_valid & e_regwrite & (e_rd != 5'd0);
  assign exmem_instr    = e_instr;
  assign exmem_fwd_data = e_aluout;
  assign exmem_is_load  = e_valid & e_memread;

endmodule
